// File: rtl/mem_lsu_pkg.sv
// Shared encodings for the MEM-stage load/store unit.
//   size   : access size and extension mode of a memory op
//   wb_sel : writeback source select
//   err    : completion error codes
//   state  : handshake FSM states
package mem_lsu_pkg;

  localparam logic [1:0] SZ_WORD     = 2'b00;
  localparam logic [1:0] SZ_BYTE_Z   = 2'b01;
  localparam logic [1:0] SZ_BYTE_S   = 2'b10;
  localparam logic [1:0] SZ_WORD_ALT = 2'b11;

  localparam logic [1:0] WB_PC   = 2'b00;
  localparam logic [1:0] WB_ALU  = 2'b01;
  localparam logic [1:0] WB_MEM  = 2'b10;
  localparam logic [1:0] WB_ZERO = 2'b11;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } lsu_state_t;

  // Both 00 and 11 are word accesses; only 01/10 touch a single byte.
  function automatic logic is_byte_size(input logic [1:0] sz);
    return (sz == SZ_BYTE_Z) || (sz == SZ_BYTE_S);
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Byte-lane helper for the load/store unit (purely combinational).
//   size       : access size code
//   lane       : byte lane inside the word (low address bits)
//   rdata      : full memory word read back
//   wsrc       : store source data
//   load_data  : rdata with the selected byte zero/sign-extended, or rdata for words
//   store_data : wsrc, or wsrc[7:0] replicated to every lane for byte stores
//   be         : all ones for words, one-hot at lane for bytes
module mem_load_align
  import mem_lsu_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [1:0]                  size,
  input  logic [$clog2(DATA_W/8)-1:0] lane,
  input  logic [DATA_W-1:0]           rdata,
  input  logic [DATA_W-1:0]           wsrc,
  output logic [DATA_W-1:0]           load_data,
  output logic [DATA_W-1:0]           store_data,
  output logic [DATA_W/8-1:0]         be
);

  localparam int LANES  = DATA_W / 8;
  localparam int LANE_W = $clog2(LANES);

  logic       byte_op;
  logic [7:0] sel_byte;

  assign byte_op = is_byte_size(size);

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign store_data[gi*8 +: 8] = byte_op ? wsrc[7:0] : wsrc[gi*8 +: 8];
      assign be[gi]                = !byte_op || (lane == LANE_W'(gi));
    end
  endgenerate

  // Loop compare rather than array index so a non-power-of-two lane count
  // never reads past the word.
  always_comb begin
    sel_byte = '0;
    for (int i = 0; i < LANES; i++) begin
      if (lane == LANE_W'(i)) begin
        sel_byte = rdata[i*8 +: 8];
      end
    end
  end

  assign load_data = byte_op
    ? {{(DATA_W-8){(size == SZ_BYTE_S) && sel_byte[7]}}, sel_byte}
    : rdata;

endmodule

// File: rtl/mem_stage_lsu.sv
// Pipeline MEM stage with a req/ack load/store unit.
//   in_valid/in_ready          : op handshake from EX/MEM (in_ready low = stall)
//   alu_result, immediate,
//   value_b, pc, data_in_src,
//   mem_rd, mem_wr, size,
//   wb_sel                     : op fields
//   mem_req/we/addr/wdata/be   : request to data memory, held until mem_ack
//   mem_ack/mem_rdata          : memory completion, rdata valid with ack
//   out_valid/wb_data          : one-cycle writeback pulse to MEM/WB
//   err/err_code               : misaligned or timed-out access, with out_valid
module mem_stage_lsu
  import mem_lsu_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   alu_result,
  input  logic [DATA_W-1:0]   immediate,
  input  logic [DATA_W-1:0]   value_b,
  input  logic [DATA_W-1:0]   pc,
  input  logic                data_in_src,
  input  logic                mem_rd,
  input  logic                mem_wr,
  input  logic [1:0]          size,
  input  logic [1:0]          wb_sel,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                out_valid,
  output logic [DATA_W-1:0]   wb_data,
  output logic                err,
  output logic [1:0]          err_code
);

  localparam int LANES  = DATA_W / 8;
  localparam int LANE_W = $clog2(LANES);
  localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit TIMEOUT_EN = (TIMEOUT > 0);

  lsu_state_t        state_reg, state_next;
  logic              mem_req_reg, mem_req_next;
  logic              mem_we_reg, mem_we_next;
  logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
  logic [DATA_W-1:0] mem_wdata_reg, mem_wdata_next;
  logic [LANES-1:0]  mem_be_reg, mem_be_next;
  logic              out_valid_reg, out_valid_next;
  logic [DATA_W-1:0] wb_data_reg, wb_data_next;
  logic              err_reg, err_next;
  logic [1:0]        err_code_reg, err_code_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  // Op fields captured at accept for use when the access completes.
  logic [1:0]        wb_sel_reg, wb_sel_next;
  logic [1:0]        size_reg, size_next;
  logic              load_reg, load_next;
  logic [DATA_W-1:0] pc_reg, pc_next;
  logic [DATA_W-1:0] alu_reg, alu_next;

  logic              accept;
  logic              is_mem;
  logic              misaligned;
  logic [DATA_W-1:0] store_src;
  logic [1:0]        align_size;
  logic [LANE_W-1:0] align_lane;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] store_data;
  logic [LANES-1:0]  store_be;

  assign in_ready   = (state_reg == ST_IDLE) && rst_n;
  assign accept     = in_valid && in_ready;
  assign is_mem     = mem_rd || mem_wr;
  assign misaligned = !is_byte_size(size) && (alu_result[LANE_W-1:0] != '0);
  assign store_src  = data_in_src ? value_b : immediate;

  // One aligner serves both directions: in IDLE it shapes store data and byte
  // enables from the incoming op, in BUSY it extracts the load lane using the
  // captured address and size.
  assign align_size = (state_reg == ST_IDLE) ? size : size_reg;
  assign align_lane = (state_reg == ST_IDLE) ? alu_result[LANE_W-1:0]
                                             : mem_addr_reg[LANE_W-1:0];

  mem_load_align #(.DATA_W(DATA_W)) u_align (
    .size       (align_size),
    .lane       (align_lane),
    .rdata      (mem_rdata),
    .wsrc       (store_src),
    .load_data  (load_data),
    .store_data (store_data),
    .be         (store_be)
  );

  function automatic logic [DATA_W-1:0] wb_pick(input logic [1:0]        sel,
                                                input logic [DATA_W-1:0] pc_v,
                                                input logic [DATA_W-1:0] alu_v,
                                                input logic [DATA_W-1:0] mem_v);
    case (sel)
      WB_PC:   return pc_v;
      WB_ALU:  return alu_v;
      WB_MEM:  return mem_v;
      default: return '0;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      mem_be_reg    <= '0;
      out_valid_reg <= 1'b0;
      wb_data_reg   <= '0;
      err_reg       <= 1'b0;
      err_code_reg  <= ERR_NONE;
      cnt_reg       <= '0;
      wb_sel_reg    <= '0;
      size_reg      <= '0;
      load_reg      <= 1'b0;
      pc_reg        <= '0;
      alu_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      mem_req_reg   <= mem_req_next;
      mem_we_reg    <= mem_we_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      mem_be_reg    <= mem_be_next;
      out_valid_reg <= out_valid_next;
      wb_data_reg   <= wb_data_next;
      err_reg       <= err_next;
      err_code_reg  <= err_code_next;
      cnt_reg       <= cnt_next;
      wb_sel_reg    <= wb_sel_next;
      size_reg      <= size_next;
      load_reg      <= load_next;
      pc_reg        <= pc_next;
      alu_reg       <= alu_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    mem_req_next   = mem_req_reg;
    mem_we_next    = mem_we_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    mem_be_next    = mem_be_reg;
    out_valid_next = 1'b0;
    wb_data_next   = wb_data_reg;
    err_next       = 1'b0;
    err_code_next  = ERR_NONE;
    cnt_next       = cnt_reg;
    wb_sel_next    = wb_sel_reg;
    size_next      = size_reg;
    load_next      = load_reg;
    pc_next        = pc_reg;
    alu_next       = alu_reg;

    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          if (!is_mem) begin
            out_valid_next = 1'b1;
            wb_data_next   = wb_pick(wb_sel, pc, alu_result, '0);
          end else if (misaligned) begin
            out_valid_next = 1'b1;
            err_next       = 1'b1;
            err_code_next  = ERR_MISALIGN;
            wb_data_next   = '0;
          end else begin
            state_next     = ST_BUSY;
            mem_req_next   = 1'b1;
            mem_we_next    = mem_wr;
            mem_addr_next  = ADDR_W'(alu_result);
            mem_wdata_next = store_data;
            mem_be_next    = store_be;
            cnt_next       = '0;
            wb_sel_next    = wb_sel;
            size_next      = size;
            // A store wins when both mem_rd and mem_wr are set.
            load_next      = !mem_wr;
            pc_next        = pc;
            alu_next       = alu_result;
          end
        end
      end
      ST_BUSY: begin
        // Ack is tested first so an ack on the final timeout cycle completes.
        if (mem_ack) begin
          state_next     = ST_IDLE;
          mem_req_next   = 1'b0;
          mem_we_next    = 1'b0;
          out_valid_next = 1'b1;
          wb_data_next   = wb_pick(wb_sel_reg, pc_reg, alu_reg,
                                   load_reg ? load_data : '0);
        end else if (TIMEOUT_EN && (cnt_reg == CNT_LAST)) begin
          state_next     = ST_IDLE;
          mem_req_next   = 1'b0;
          mem_we_next    = 1'b0;
          out_valid_next = 1'b1;
          err_next       = 1'b1;
          err_code_next  = ERR_TIMEOUT;
          wb_data_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign mem_req   = mem_req_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign mem_be    = mem_be_reg;
  assign out_valid = out_valid_reg;
  assign wb_data   = wb_data_reg;
  assign err       = err_reg;
  assign err_code  = err_code_reg;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: a 16-bit instance (default timeout) and a
// 32-bit instance with TIMEOUT=4 share the op buses; each has its own
// in_valid/mem_ack. Expected writebacks are queued when an op is driven and
// popped by a monitor whenever that instance pulses out_valid.
module tb_mem_stage_lsu;
  import mem_lsu_pkg::*;

  localparam int TMO_B = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] alu_result, immediate, value_b, pc, mem_rdata;
  logic        data_in_src, mem_rd, mem_wr;
  logic [1:0]  size, wb_sel;
  logic        a_in_valid, b_in_valid, a_mem_ack, b_mem_ack;

  logic        a_in_ready, a_mem_req, a_mem_we, a_out_valid, a_err;
  logic [15:0] a_mem_addr, a_mem_wdata, a_wb_data;
  logic [1:0]  a_mem_be, a_err_code;
  logic        b_in_ready, b_mem_req, b_mem_we, b_out_valid, b_err;
  logic [15:0] b_mem_addr;
  logic [31:0] b_mem_wdata, b_wb_data;
  logic [3:0]  b_mem_be;
  logic [1:0]  b_err_code;

  mem_stage_lsu #(.DATA_W(16), .ADDR_W(16), .TIMEOUT(64)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .alu_result(alu_result[15:0]), .immediate(immediate[15:0]), .value_b(value_b[15:0]),
    .pc(pc[15:0]), .data_in_src(data_in_src), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .size(size), .wb_sel(wb_sel), .mem_req(a_mem_req), .mem_we(a_mem_we),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_be(a_mem_be),
    .mem_ack(a_mem_ack), .mem_rdata(mem_rdata[15:0]), .out_valid(a_out_valid),
    .wb_data(a_wb_data), .err(a_err), .err_code(a_err_code)
  );

  mem_stage_lsu #(.DATA_W(32), .ADDR_W(16), .TIMEOUT(TMO_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .alu_result(alu_result), .immediate(immediate), .value_b(value_b),
    .pc(pc), .data_in_src(data_in_src), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .size(size), .wb_sel(wb_sel), .mem_req(b_mem_req), .mem_we(b_mem_we),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_be(b_mem_be),
    .mem_ack(b_mem_ack), .mem_rdata(mem_rdata), .out_valid(b_out_valid),
    .wb_data(b_wb_data), .err(b_err), .err_code(b_err_code)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] wb;
    logic        err;
    logic [1:0]  code;
  } exp_t;
  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;

  // Observation mux so one task can drive either instance.
  bit          sel_b = 1'b0;
  logic        o_ready, o_req, o_we, o_valid;
  logic [15:0] o_addr;
  logic [31:0] o_wdata;
  logic [3:0]  o_be;
  assign o_ready = sel_b ? b_in_ready  : a_in_ready;
  assign o_req   = sel_b ? b_mem_req   : a_mem_req;
  assign o_we    = sel_b ? b_mem_we    : a_mem_we;
  assign o_valid = sel_b ? b_out_valid : a_out_valid;
  assign o_addr  = sel_b ? b_mem_addr  : a_mem_addr;
  assign o_wdata = sel_b ? b_mem_wdata : {16'h0, a_mem_wdata};
  assign o_be    = sel_b ? b_mem_be    : {2'b00, a_mem_be};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    if (a_out_valid === 1'b1) begin
      if (q_a.size() == 0) begin
        check("a_spurious_out_valid", 64'(a_out_valid), 64'(0));
      end else begin
        ea = q_a.pop_front();
        check("a_wb_err", 64'({a_wb_data, a_err, a_err_code}), 64'({ea.wb[15:0], ea.err, ea.code}));
      end
    end
    if (b_out_valid === 1'b1) begin
      if (q_b.size() == 0) begin
        check("b_spurious_out_valid", 64'(b_out_valid), 64'(0));
      end else begin
        eb = q_b.pop_front();
        check("b_wb_err", 64'({b_wb_data, b_err, b_err_code}), 64'({eb.wb, eb.err, eb.code}));
      end
    end
  end

  task automatic push_exp(input bit use_b, input logic [31:0] wb, input logic e, input logic [1:0] code);
    exp_t x;
    x.wb = wb; x.err = e; x.code = code;
    if (use_b) q_b.push_back(x); else q_a.push_back(x);
  endtask

  // One op from accept to completion. ack_at = request cycle carrying mem_ack
  // (1 = zero-wait); 0 = never ack, expecting timeout after TMO_B cycles.
  task automatic run_op(input bit use_b, input string tag, input logic [31:0] alu,
                        input logic [31:0] sdata, input logic src, input logic rd,
                        input logic wr, input logic [1:0] sz, input logic [1:0] ws,
                        input logic [31:0] rdata, input int ack_at, input bit exp_req,
                        input logic [31:0] exp_wdata, input logic [3:0] exp_be,
                        input logic [31:0] exp_wb, input logic exp_err,
                        input logic [1:0] exp_code);
    int ncyc;
    sel_b       = use_b;
    alu_result  = alu;
    data_in_src = src;
    value_b     = src ? sdata : ~sdata;
    immediate   = src ? ~sdata : sdata;
    mem_rd      = rd;
    mem_wr      = wr;
    size        = sz;
    wb_sel      = ws;
    mem_rdata   = 32'hCAFE_F00D;
    push_exp(use_b, exp_wb, exp_err, exp_code);
    if (use_b) b_in_valid = 1'b1; else a_in_valid = 1'b1;
    check({tag, "_in_ready"}, 64'(o_ready), 64'(1));
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
    if (!exp_req) begin
      check({tag, "_noreq_valid"}, 64'({o_req, o_valid}), 64'({1'b0, 1'b1}));
    end else begin
      ncyc = (ack_at > 0) ? ack_at : TMO_B;
      for (int i = 1; i <= ncyc; i++) begin
        check({tag, $sformatf("_busy%0d", i)},
              64'({o_req, o_ready, o_we, o_addr, wr ? o_wdata : 32'h0, o_be}),
              64'({1'b1, 1'b0, wr, alu[15:0], wr ? exp_wdata : 32'h0, exp_be}));
        if (i == ack_at) begin
          if (use_b) b_mem_ack = 1'b1; else a_mem_ack = 1'b1;
          mem_rdata = rdata;
        end
        @(posedge clk); #1;
        a_mem_ack = 1'b0;
        b_mem_ack = 1'b0;
        mem_rdata = 32'hCAFE_F00D;
      end
      check({tag, "_done"}, 64'({o_req, o_valid}), 64'({1'b0, 1'b1}));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    alu_result = '0; immediate = '0; value_b = '0; pc = 32'h0000_0010; mem_rdata = '0;
    data_in_src = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; size = SZ_WORD; wb_sel = WB_PC;
    a_in_valid = 1'b0; b_in_valid = 1'b0; a_mem_ack = 1'b0; b_mem_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("a_reset_state", 64'({a_in_ready, a_mem_req, a_mem_we, a_out_valid, a_err, a_err_code,
                                a_wb_data, a_mem_addr, a_mem_wdata, a_mem_be}), 64'(0));
    check("b_reset_ctl", 64'({b_in_ready, b_mem_req, b_mem_we, b_out_valid, b_err, b_err_code,
                              b_mem_addr, b_mem_be}), 64'(0));
    check("b_reset_data", 64'({b_wb_data, b_mem_wdata}), 64'(0));
    rst_n = 1'b1;
    #1;

    // 16-bit instance
    run_op(0, "a_st_word", 32'h0004, 32'h5678, 1, 0, 1, SZ_WORD, WB_MEM, 32'hDEAD, 1, 1,
           32'h5678, 4'b0011, 32'h0000, 0, ERR_NONE);
    run_op(0, "a_ld_word", 32'h0004, 32'h0000, 1, 1, 0, SZ_WORD, WB_MEM, 32'h5678, 1, 1,
           32'h0, 4'b0011, 32'h5678, 0, ERR_NONE);
    run_op(0, "a_ld_bs", 32'h0005, 32'h0000, 0, 1, 0, SZ_BYTE_S, WB_MEM, 32'h80FF, 1, 1,
           32'h0, 4'b0010, 32'hFF80, 0, ERR_NONE);
    run_op(0, "a_ld_bz", 32'h0004, 32'h0000, 0, 1, 0, SZ_BYTE_Z, WB_MEM, 32'h80FF, 1, 1,
           32'h0, 4'b0001, 32'h00FF, 0, ERR_NONE);
    run_op(0, "a_st_byte", 32'h0007, 32'h00AB, 0, 0, 1, SZ_BYTE_Z, WB_PC, 32'h0, 1, 1,
           32'hABAB, 4'b0010, 32'h0010, 0, ERR_NONE);
    run_op(0, "a_misalign", 32'h0003, 32'h0000, 0, 1, 0, SZ_WORD, WB_ALU, 32'h0, 1, 0,
           32'h0, 4'b0000, 32'h0000, 1, ERR_MISALIGN);
    run_op(0, "a_ld_wait5", 32'h0008, 32'h0000, 0, 1, 0, SZ_WORD_ALT, WB_MEM, 32'h1234, 5, 1,
           32'h0, 4'b0011, 32'h1234, 0, ERR_NONE);
    run_op(0, "a_rdwr_prec", 32'h000C, 32'h9ABC, 1, 1, 1, SZ_WORD, WB_ALU, 32'h4444, 2, 1,
           32'h9ABC, 4'b0011, 32'h000C, 0, ERR_NONE);

    // Back-to-back non-memory ops, one per cycle
    sel_b = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; size = SZ_WORD;
    pc = 32'h0000_0010; alu_result = 32'h0000_0022;
    a_in_valid = 1'b1;
    wb_sel = WB_PC;   push_exp(0, 32'h0010, 0, ERR_NONE);
    @(posedge clk); #1;
    check("a_b2b_v1", 64'({a_out_valid, a_in_ready}), 64'({1'b1, 1'b1}));
    wb_sel = WB_ALU;  push_exp(0, 32'h0022, 0, ERR_NONE);
    @(posedge clk); #1;
    check("a_b2b_v2", 64'(a_out_valid), 64'(1));
    wb_sel = WB_ZERO; push_exp(0, 32'h0000, 0, ERR_NONE);
    @(posedge clk); #1;
    check("a_b2b_v3", 64'(a_out_valid), 64'(1));
    wb_sel = WB_MEM;  push_exp(0, 32'h0000, 0, ERR_NONE);
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    check("a_b2b_v4", 64'(a_out_valid), 64'(1));
    @(posedge clk); #1;
    check("a_b2b_idle", 64'(a_out_valid), 64'(0));

    // Reset while an access is outstanding; the late ack must be ignored.
    sel_b = 1'b0; alu_result = 32'h000A; mem_rd = 1'b1; mem_wr = 1'b0;
    size = SZ_WORD; wb_sel = WB_MEM; a_in_valid = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    check("a_rst_busy_req", 64'(a_mem_req), 64'(1));
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("a_rst_busy_clear", 64'({a_mem_req, a_out_valid, a_in_ready}), 64'(0));
    rst_n = 1'b1;
    #1;
    check("a_rst_ready", 64'(a_in_ready), 64'(1));
    a_mem_ack = 1'b1; mem_rdata = 32'h5555;
    @(posedge clk); #1;
    a_mem_ack = 1'b0;
    check("a_ack_idle_ignored", 64'({a_mem_req, a_out_valid, a_in_ready}), 64'(3'b001));
    run_op(0, "a_after_rst", 32'h0042, 32'h0, 0, 0, 0, SZ_WORD, WB_ALU, 32'h0, 1, 0,
           32'h0, 4'b0000, 32'h0042, 0, ERR_NONE);

    // 32-bit instance, TIMEOUT=4
    run_op(1, "b_st_byte", 32'h0007, 32'h0000_00AB, 0, 0, 1, SZ_BYTE_Z, WB_ALU, 32'h0, 1, 1,
           32'hABAB_ABAB, 4'b1000, 32'h0000_0007, 0, ERR_NONE);
    run_op(1, "b_ld_bs_l2", 32'h0006, 32'h0, 0, 1, 0, SZ_BYTE_S, WB_MEM, 32'h80FF_7F01, 1, 1,
           32'h0, 4'b0100, 32'hFFFF_FFFF, 0, ERR_NONE);
    run_op(1, "b_ld_bs_l1", 32'h0005, 32'h0, 0, 1, 0, SZ_BYTE_S, WB_MEM, 32'h80FF_7F01, 1, 1,
           32'h0, 4'b0010, 32'h0000_007F, 0, ERR_NONE);
    run_op(1, "b_ld_bz_l3", 32'h0007, 32'h0, 0, 1, 0, SZ_BYTE_Z, WB_MEM, 32'h80FF_7F01, 1, 1,
           32'h0, 4'b1000, 32'h0000_0080, 0, ERR_NONE);
    run_op(1, "b_misalign", 32'h0006, 32'h0, 0, 1, 0, SZ_WORD, WB_ALU, 32'h0, 1, 0,
           32'h0, 4'b0000, 32'h0, 1, ERR_MISALIGN);
    run_op(1, "b_ld_word", 32'h0004, 32'h0, 0, 1, 0, SZ_WORD, WB_MEM, 32'h80FF_7F01, 3, 1,
           32'h0, 4'b1111, 32'h80FF_7F01, 0, ERR_NONE);
    run_op(1, "b_timeout", 32'h0008, 32'h0, 0, 1, 0, SZ_WORD, WB_ALU, 32'h0, 0, 1,
           32'h0, 4'b1111, 32'h0, 1, ERR_TIMEOUT);
    run_op(1, "b_ack_last", 32'h000C, 32'h0, 0, 1, 0, SZ_WORD, WB_MEM, 32'h1357_9BDF, TMO_B, 1,
           32'h0, 4'b1111, 32'h1357_9BDF, 0, ERR_NONE);
    run_op(1, "b_st_word", 32'h0010, 32'h1122_3344, 1, 0, 1, SZ_WORD, WB_PC, 32'h0, 2, 1,
           32'h1122_3344, 4'b1111, 32'h0000_0010, 0, ERR_NONE);

    repeat (3) @(posedge clk);
    #1;
    check("a_queue_drained", 64'(q_a.size()), 64'(0));
    check("b_queue_drained", 64'(q_b.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
